mvm_uart_host: RTL and testbench
================================

// Module: mvm_uart_host
// PURPOSE
//  Host-side initiator for the MVM-over-UART accelerator; the FPGA test harness uses it to drive the chip.
//  - Takes one packed operand word (K matrix + X vector) on a valid/ready input.
//  - Sends it as 8N1 UART bytes on tx, then receives the R result bytes on rx.
//  - Returns the results, or a timeout/framing error, on a valid/ready output.
// PARAMETERS
//  CLOCKS_PER_PULSE  2604  clock cycles per UART bit (50 MHz / 19200)
//  BITS_PER_WORD     8     data bits per UART frame
//  R                 2     matrix rows = number of result words
//  C                 2     matrix columns = vector length
//  W_X               4     width of each X element
//  W_K               2     width of each K element
//  W_Y_OUT           8     width of each result word
//  TIMEOUT_PULSES    64    bit periods allowed idle in RX_WAIT before error
//  Derived: W_IN=R*C*W_K+C*W_X (16); N_TX=ceil(W_IN/8) (2); N_RX=ceil(R*W_Y_OUT/8) (2)
// PORTS
//  clk      in   1          clock; single clock domain
//  rst      in   1          synchronous, active-high reset
//  s_valid  in   1          operand word valid
//  s_ready  out  1          high only in IDLE
//  s_data   in   W_IN       {K[R*C*W_K-1:0], X[C*W_X-1:0]}; X in the low bits
//  tx       out  1          UART line to device (idle high)
//  rx       in   1          UART line from device (asynchronous; 2-FF synchronised)
//  m_valid  out  1          result/error valid; held until m_ready
//  m_ready  in   1          result accepted
//  m_data   out  R*W_Y_OUT  result bytes; byte i at [8i+7:8i]
//  m_error  out  1          qualifies m_valid: 1 = timeout or framing error
//  busy     out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: tx=1, s_ready=0 during rst and 1 the cycle after, m_valid=0, m_error=0, m_data=0, busy=0,
//    state=IDLE, all counters 0. The reset values apply the cycle after rst is sampled high,
//    including mid-frame: tx returns high immediately and no partial byte completes.
//  States:
//    IDLE -> TX    on s_valid&s_ready; latch s_data, zero-padded to N_TX*8 bits.
//    TX   -> RX_WAIT  after last stop bit of byte N_TX-1.
//    RX_WAIT -> RX_BYTE  on synced rx low.
//    RX_WAIT -> DONE(err)  after TIMEOUT_PULSES*CLOCKS_PER_PULSE cycles with no start bit.
//    RX_BYTE -> RX_WAIT  next byte.  RX_BYTE -> DONE(ok)  after byte N_RX-1.
//    RX_BYTE -> DONE(err)  on bad stop bit.
//    DONE -> IDLE  on m_valid&m_ready.
//  TX framing:
//    - Bytes go least-significant byte first.
//    - Each frame: start(0), 8 data bits LSB first, stop(1); each bit held exactly CLOCKS_PER_PULSE cycles.
//    - Frames are back-to-back, with no gap between frames.
//    - tx falls on the cycle after the accepting handshake.
//  rx is ignored outside RX_WAIT/RX_BYTE. A start bit arriving during TX is not captured.
//  RX sampling:
//    - Start candidate is re-checked at CLOCKS_PER_PULSE/2. If rx is high there, it is a glitch:
//      stay in RX_WAIT, and do not reset the timeout counter.
//    - Data bits are sampled at mid-bit, each CLOCKS_PER_PULSE after the previous sample.
//    - Stop bit is sampled at mid-bit: 1 = byte ok, 0 = framing error.
//    - Any idle time after the stop bit is tolerated; the device frame is 13 bit periods.
//    - The timeout counter restarts at each entry to RX_WAIT.
//  DONE:
//    - m_valid=1. m_data holds all received bytes, with missing bytes 0 on error.
//    - m_error = 1 for timeout/framing, 0 for success.
//    - m_data/m_error are stable while m_valid=1 and m_ready=0.
//    - With m_ready=1, m_valid drops the next cycle and s_ready rises the same cycle (IDLE).
//  s_valid is ignored outside IDLE; s_data is sampled only at the handshake.
//  Counters: the bit-timer is wide enough for CLOCKS_PER_PULSE-1. The timeout counter is wide enough for
//    TIMEOUT_PULSES*CLOCKS_PER_PULSE. No counter ever wraps.
// TESTING (bench uses CLOCKS_PER_PULSE=8, TIMEOUT_PULSES=4)
//  1. s_data=16'hA53C -> tx carries 0x3C then 0xA5, 8N1, 80 cycles each. tx falls 1 cycle after handshake.
//     Device model then replies 0x12,0x34 -> m_valid with m_data=16'h3412, m_error=0.
//  2. Hold m_ready=0 for 20 cycles after case 1 -> m_valid/m_data stable, s_ready=0.
//     Raise m_ready -> IDLE next cycle.
//  3. No reply after TX -> m_valid with m_error=1 and m_data=0 exactly 32 cycles after entering RX_WAIT.
//  4. Reply 0x55 with stop bit 0 -> m_error=1, m_data=16'h0055.
//  5. 2-cycle low glitch on rx in RX_WAIT, then valid bytes 0x01,0x02 -> glitch ignored, m_data=16'h0201.
//  6. Assert rst mid-way through the second TX byte -> next cycle tx=1, busy=0.
//     Then s_ready=1 after rst drops; a fresh transaction completes normally.

Source files
------------

// File: rtl/mvm_uart_host.sv
// Host-side initiator for the MVM-over-UART accelerator: sends one packed operand word
// as 8N1 frames on tx, then collects the result bytes from rx or reports timeout/framing error.
//
// state     | meaning
// S_IDLE    | waiting for an operand word, s_ready high
// S_TX      | shifting operand bytes out on tx, LSB byte first
// S_RX_WAIT | line idle, waiting for a start bit; timeout running
// S_RX_BYTE | start-bit check at half period, then mid-bit data and stop sampling
// S_DONE    | result or error presented on m_valid until m_ready
module mvm_uart_host #(
    parameter int CLOCKS_PER_PULSE = 2604,
    parameter int BITS_PER_WORD    = 8,
    parameter int R                = 2,
    parameter int C                = 2,
    parameter int W_X              = 4,
    parameter int W_K              = 2,
    parameter int W_Y_OUT          = 8,
    parameter int TIMEOUT_PULSES   = 64,
    localparam int W_IN  = R*C*W_K + C*W_X,
    localparam int W_OUT = R*W_Y_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_IN-1:0]  s_data,
    output logic             tx,
    input  logic             rx,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W_OUT-1:0] m_data,
    output logic             m_error,
    output logic             busy
);
    localparam int N_TX  = (W_IN + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int N_RX  = (W_OUT + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int TXB   = N_TX*BITS_PER_WORD;
    localparam int RXB   = N_RX*BITS_PER_WORD;
    localparam int TW    = (CLOCKS_PER_PULSE > 2) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int OW    = $clog2(TIMEOUT_PULSES*CLOCKS_PER_PULSE + 1);
    localparam int BW    = $clog2(BITS_PER_WORD + 2);
    localparam int IW    = $clog2(((N_TX > N_RX) ? N_TX : N_RX) + 1);

    localparam logic [TW-1:0] BIT_LAST = TW'(CLOCKS_PER_PULSE - 1);
    localparam logic [TW-1:0] BIT_HALF = TW'(CLOCKS_PER_PULSE/2 - 1);
    localparam logic [OW-1:0] TO_LAST  = OW'(TIMEOUT_PULSES*CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_STOP = BW'(BITS_PER_WORD + 1);
    localparam logic [BW-1:0] BIT_DATA = BW'(BITS_PER_WORD);
    localparam logic [IW-1:0] TX_LAST  = IW'(N_TX - 1);
    localparam logic [IW-1:0] RX_LAST  = IW'(N_RX - 1);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_WAIT, S_RX_BYTE, S_DONE} state_t;

    state_t                   state;
    logic [TXB-1:0]           tx_buf;
    logic [RXB-1:0]           rx_buf;
    logic [BITS_PER_WORD-1:0] rx_shift;
    logic [TW-1:0]            bit_timer;
    logic [OW-1:0]            to_timer;
    logic [BW-1:0]            bit_idx;
    logic [IW-1:0]            byte_idx;
    logic                     rx_meta, rx_sync;

    assign m_data = rx_buf[W_OUT-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_buf    <= '0;
            rx_buf    <= '0;
            rx_shift  <= '0;
            bit_timer <= '0;
            to_timer  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            tx        <= 1'b1;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            m_error   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            case (state)
                S_IDLE: begin
                    tx      <= 1'b1;
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        tx_buf    <= TXB'(s_data);
                        rx_buf    <= '0;
                        tx        <= 1'b0;
                        bit_timer <= BIT_LAST;
                        bit_idx   <= '0;
                        byte_idx  <= '0;
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_TX;
                    end
                end
                S_TX: begin
                    if (bit_timer != '0) begin
                        bit_timer <= bit_timer - 1'b1;
                    end else begin
                        bit_timer <= BIT_LAST;
                        if (bit_idx == BIT_STOP) begin
                            bit_idx <= '0;
                            if (byte_idx == TX_LAST) begin
                                byte_idx <= '0;
                                to_timer <= TO_LAST;
                                state    <= S_RX_WAIT;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                tx       <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            // tx_buf shifts one bit per data bit, so the next byte lands at the bottom
                            if (bit_idx < BIT_DATA) begin
                                tx     <= tx_buf[0];
                                tx_buf <= tx_buf >> 1;
                            end else begin
                                tx <= 1'b1;
                            end
                        end
                    end
                end
                S_RX_WAIT: begin
                    if (to_timer != '0)
                        to_timer <= to_timer - 1'b1;
                    if (!rx_sync) begin
                        bit_timer <= BIT_HALF;
                        bit_idx   <= '0;
                        state     <= S_RX_BYTE;
                    end else if (to_timer == '0) begin
                        m_valid <= 1'b1;
                        m_error <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_RX_BYTE: begin
                    // a rejected glitch returns to RX_WAIT with the idle time still counted
                    if (to_timer != '0)
                        to_timer <= to_timer - 1'b1;
                    if (bit_timer != '0) begin
                        bit_timer <= bit_timer - 1'b1;
                    end else begin
                        bit_timer <= BIT_LAST;
                        if (bit_idx == '0) begin
                            if (rx_sync)
                                state <= S_RX_WAIT;
                            else
                                bit_idx <= bit_idx + 1'b1;
                        end else if (bit_idx != BIT_STOP) begin
                            rx_shift <= {rx_sync, rx_shift[BITS_PER_WORD-1:1]};
                            bit_idx  <= bit_idx + 1'b1;
                        end else begin
                            for (int i = 0; i < N_RX; i++)
                                if (byte_idx == IW'(i))
                                    rx_buf[i*BITS_PER_WORD +: BITS_PER_WORD] <= rx_shift;
                            bit_idx <= '0;
                            if (!rx_sync) begin
                                m_valid <= 1'b1;
                                m_error <= 1'b1;
                                state   <= S_DONE;
                            end else if (byte_idx == RX_LAST) begin
                                m_valid <= 1'b1;
                                m_error <= 1'b0;
                                state   <= S_DONE;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                to_timer <= TO_LAST;
                                state    <= S_RX_WAIT;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_error <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_uart_host.sv
// Bench for mvm_uart_host: directed transactions with a tx frame monitor and a result
// scoreboard, both fed expected values by the stimulus thread.
module tb_mvm_uart_host;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        tx;
    logic        rx;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_error;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int hs_cyc = 0;

    logic [7:0]  exp_tx[$];
    logic [16:0] exp_res[$];

    mvm_uart_host #(.CLOCKS_PER_PULSE(8), .TIMEOUT_PULSES(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .tx(tx), .rx(rx),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_error(m_error),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic [15:0] d);
        int g;
        exp_tx.push_back(d[7:0]);
        exp_tx.push_back(d[15:8]);
        s_valid = 1'b1;
        s_data  = d;
        g = 0;
        while (s_ready !== 1'b1 && g < 200) begin
            tick();
            g++;
        end
        check("s_ready_wait", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        hs_cyc  = cyc;
        s_valid = 1'b0;
        s_data  = 16'hFFFF;
        @(negedge clk);
        check("tx_fall_after_hs", 32'(tx), 32'd0);
        check("busy_after_hs", 32'(busy), 32'd1);
        check("s_ready_after_hs", 32'(s_ready), 32'd0);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (8) tick();
        end
        rx = 1'b1;
        repeat (24) tick();
    endtask

    task automatic wait_mvalid(input int max_cyc);
        int g;
        g = 0;
        while (m_valid !== 1'b1 && g < max_cyc) begin
            @(negedge clk);
            g++;
        end
        check("m_valid_wait", 32'(m_valid), 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int g;
        g = 0;
        while (s_ready !== 1'b1 && g < max_cyc) begin
            @(negedge clk);
            g++;
        end
        check("idle_wait", 32'(s_ready), 32'd1);
    endtask

    // tx monitor: every cycle of a frame must hold the same bit value, 8 cycles per bit
    initial begin : tx_monitor
        logic [9:0] frame;
        logic       held;
        logic       aborted;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                frame = '0;
                held = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < 8 && !aborted; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        else if (s == 0) frame[b] = tx;
                        else if (tx !== frame[b]) held = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (exp_tx.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL tx_unexpected: frame %h with no byte expected", frame);
                    end else begin
                        e = exp_tx.pop_front();
                        check("tx_frame", 32'(frame), 32'({1'b1, e, 1'b0}));
                        check("tx_bit_hold", 32'(held), 32'd1);
                    end
                end
            end
        end
    end

    // result scoreboard: compare on every accepted m_valid
    always @(negedge clk) begin
        logic [16:0] r;
        if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_res.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL res_unexpected: data %h err %b with nothing expected", m_data, m_error);
            end else begin
                r = exp_res.pop_front();
                check("m_data", 32'(m_data), 32'(r[15:0]));
                check("m_error", 32'(m_error), 32'(r[16]));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int ok;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; rx = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_error", 32'(m_error), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("s_ready_after_rst", 32'(s_ready), 32'd1);

        // cases 1 and 2: normal reply, result held while m_ready low
        m_ready = 1'b0;
        exp_res.push_back({1'b0, 16'h3412});
        start_word(16'hA53C);
        repeat (164) tick();
        uart_send(8'h12, 1'b1);
        uart_send(8'h34, 1'b1);
        wait_mvalid(200);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid === 1'b1 && m_data === 16'h3412 && m_error === 1'b0 &&
                s_ready === 1'b0 && busy === 1'b1) ok++;
        end
        check("hold_stable_cycles", 32'(ok), 32'd20);
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_m_valid", 32'(m_valid), 32'd0);
        check("release_s_ready", 32'(s_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);

        // case 3: no reply -> timeout 2*80 + 32 cycles after the handshake
        exp_res.push_back({1'b1, 16'h0000});
        start_word(16'h0F0F);
        wait_mvalid(400);
        check("timeout_latency", 32'(cyc - hs_cyc), 32'd192);
        wait_idle(50);

        // case 4: framing error keeps the received byte
        exp_res.push_back({1'b1, 16'h0055});
        start_word(16'hC35A);
        repeat (164) tick();
        uart_send(8'h55, 1'b0);
        wait_idle(200);

        // case 5: short glitch then a valid reply
        exp_res.push_back({1'b0, 16'h0201});
        start_word(16'h7E81);
        repeat (164) tick();
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (6) tick();
        uart_send(8'h01, 1'b1);
        uart_send(8'h02, 1'b1);
        wait_idle(200);

        // case 6: reset in the middle of the second tx byte
        start_word(16'h1234);
        repeat (120) tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        tick();
        rst = 1'b0;
        exp_tx.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_s_ready_after", 32'(s_ready), 32'd1);

        exp_res.push_back({1'b0, 16'h8877});
        start_word(16'hBEEF);
        repeat (164) tick();
        uart_send(8'h77, 1'b1);
        uart_send(8'h88, 1'b1);
        wait_idle(200);

        repeat (10) tick();
        check("tx_queue_left", 32'(exp_tx.size()), 32'd0);
        check("res_queue_left", 32'(exp_res.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
